// File: rtl/jal_encoder.sv
// RV32I jal instruction encoder: (pc, target, rd) -> instruction word plus error code.
// Optional macro JAL_ENCODER_STATS_EN builds the saturating success/failure counters.
module jal_encoder (
  input  logic        clk,
  input  logic        clrn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_pc,
  input  logic [31:0] req_target,
  input  logic [4:0]  req_rd,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_inst,
  output logic [1:0]  rsp_err,
  output logic [15:0] enc_cnt,
  output logic [15:0] err_cnt
);

  localparam logic [1:0]  IDLE    = 2'd0;
  localparam logic [1:0]  CALC    = 2'd1;
  localparam logic [1:0]  PACK    = 2'd2;
  localparam logic [1:0]  RESP    = 2'd3;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [6:0]  OPC_JAL = 7'b1101111;

  logic [1:0]         state;
  logic [31:0]        pc_p0;
  logic [31:0]        target_p0;
  logic [4:0]         rd_p0;
  logic signed [31:0] off_p1;
  logic [1:0]         err_p1;

  // bit0: not word aligned; bit1: bits above 20 are not a sign extension of bit 20
  function automatic logic [1:0] jal_err(input logic signed [31:0] off);
    logic mis;
    logic rng;
    mis = |off[1:0];
    rng = !((&off[31:20]) || !(|off[31:20]));
    return {rng, mis};
  endfunction

  function automatic logic [31:0] jal_pack(input logic signed [31:0] off, input logic [4:0] rd);
    return {off[20], off[10:1], off[11], off[19:12], rd, OPC_JAL};
  endfunction

  assign err_p1    = jal_err(off_p1);
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state     <= IDLE;
      pc_p0     <= '0;
      target_p0 <= '0;
      rd_p0     <= '0;
      off_p1    <= '0;
      rsp_inst  <= '0;
      rsp_err   <= '0;
    end else begin
      case (state)
        // p0: capture the request
        IDLE: if (req_valid) begin
          pc_p0     <= req_pc;
          target_p0 <= req_target;
          rd_p0     <= req_rd;
          state     <= CALC;
        end
        // p1: modulo-2^32 offset, wrap-around is intentional
        CALC: begin
          off_p1 <= $signed(target_p0 - pc_p0);
          state  <= PACK;
        end
        // p2: error check and instruction packing
        PACK: begin
          rsp_err  <= err_p1;
          rsp_inst <= (err_p1 != 2'b00) ? NOP : jal_pack(off_p1, rd_p0);
          state    <= RESP;
        end
        RESP: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef JAL_ENCODER_STATS_EN
  logic [15:0] enc_cnt_q;
  logic [15:0] err_cnt_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (&c) ? c : c + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      enc_cnt_q <= '0;
      err_cnt_q <= '0;
    end else if (state == RESP && rsp_ready) begin
      if (rsp_err == 2'b00) enc_cnt_q <= sat_inc(enc_cnt_q);
      else                  err_cnt_q <= sat_inc(err_cnt_q);
    end
  end

  assign enc_cnt = enc_cnt_q;
  assign err_cnt = err_cnt_q;
`else
  assign enc_cnt = 16'd0;
  assign err_cnt = 16'd0;
`endif

endmodule
